pipeline_muldiv_ctrl: RTL and testbench
=======================================

Name: pipeline_muldiv_ctrl

Overview:
- Sequencer for an iterative multiply/divide unit attached to the pipeline EX stage.
- Owns HI/LO and runs 32-iteration shift-add multiply and restoring divide.
- Raises a pipeline stall whenever EX needs HI/LO, or issues a new mul/div, while an operation is in flight.
- Sits beside the EX ALU; its results reach writeback through the existing aluout path via a mux selected by the decoder.

Parameters:
WIDTH, 32, operand and HI/LO width
ITERS, 32, iterations per operation (must equal WIDTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  EX holds a mult/multu/div/divu and the pipeline is not flushed
op  in  2  00 mult, 01 multu, 10 div, 11 divu
srca  in  32  rs value (multiplicand / dividend)
srcb  in  32  rt value (multiplier / divisor)
mfreq  in  1  EX holds mfhi or mflo
mthi  in  1  EX holds mthi
mtlo  in  1  EX holds mtlo
wdata  in  32  rs value for mthi/mtlo
hi  out  32  HI register
lo  out  32  LO register
busy  out  1  operation in flight
stall  out  1  freeze IF/ID/EX, bubble MEM
done  out  1  one-cycle pulse when HI/LO updated by an operation
divzero  out  1  last div/divu had divisor 0; sticky until next accepted start

Behaviour:
- Reset (synchronous, active-high, also mid-operation): state=IDLE; hi=lo=0; busy=0; done=0; divzero=0. Any in-flight operation is discarded.
- States:
  - IDLE -> CALC on accepted start (start & !busy). Operands are latched that edge, with signed ops latching magnitudes and sign bits. Iteration count is set to 0.
  - CALC: one iteration per cycle. Exits to FIXUP after iteration ITERS-1.
  - FIXUP: applies sign correction, writes hi/lo, pulses done, then returns to IDLE.
- Latency: start sampled at edge N. hi/lo hold the new value after edge N+ITERS+1 (N+33). done is high during cycle N+33.
- busy: high in CALC and FIXUP.
- stall: busy & (start | mfreq | mthi | mtlo). It is combinational, so the instruction is held in EX until the unit is IDLE.
- Back-to-back starts: a start in the cycle FIXUP completes is accepted on the next edge, with no extra idle cycle required.
- mthi/mtlo when not busy: hi or lo := wdata on that edge. Simultaneous mthi & mtlo writes both.
- Multiply:
  - Unsigned 64-bit product of the magnitudes; {hi,lo} = product.
  - mult negates the 64-bit product when sign_a ^ sign_b.
  - |0x80000000| is treated as unsigned 0x80000000, so no overflow case exists.
- Divide (restoring):
  - lo = quotient, hi = remainder.
  - div: quotient negated when sign_a ^ sign_b; remainder takes the dividend's sign.
  - 0x80000000 / -1 (div) yields lo=0x80000000, hi=0.
- Divisor 0:
  - The algorithm runs unchanged and gives lo=0xFFFFFFFF, hi=|dividend| (sign-fixed for div).
  - divzero is set at FIXUP.
- srca/srcb/op changes during CALC have no effect.
- mfreq/mthi/mtlo/start are all ignored while reset is high.

Decomposition:
- Shared header muldiv_defs.vh holds:
  - op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - state encodings (S_IDLE, S_CALC, S_FIXUP)
  - ITERS default
- One natural sub-module, muldiv_step: the combinational single iteration.
  - Multiply: add/shift of the 64-bit accumulator.
  - Divide: trial subtract/shift of the remainder:quotient pair.
  - Instantiated once; pipeline_muldiv_ctrl keeps the FSM, counter and HI/LO.

Test Plan:
- multu 0xFFFFFFFF*0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done pulses once; busy low the next cycle.
- mult -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2.
- mfreq asserted 5 cycles after start -> stall high until FIXUP completes, then low; the mf instruction sees the new hi/lo.
- divu 5/0 -> lo=0xFFFFFFFF, hi=5, divzero=1. The next start clears divzero.
- reset at CALC iteration 10 -> next cycle state IDLE, hi=lo=0, busy=0, no done pulse.
- mthi 0x1234 while idle, then mult 0x80000000*0x80000000 -> hi=0x40000000, lo=0. Also div 0x80000000/-1 -> lo=0x80000000, hi=0.

Source files
------------

// File: rtl/pipeline_muldiv_ctrl_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Op codes match the decoder's 2-bit mul/div selector.
package pipeline_muldiv_ctrl_pkg;

    localparam int ITERS_DEFAULT = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CALC  = 2'b01,
        S_FIXUP = 2'b10
    } md_state_e;

    function automatic logic op_is_div(input md_op_e o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

endpackage

// File: rtl/pipeline_muldiv_ctrl_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step
// on the shared {upper, lower} accumulator.
module pipeline_muldiv_ctrl_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        trial = acc[2*WIDTH-1:WIDTH-1];
        diff  = trial - {1'b0, operand};
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            // Borrow out of the (WIDTH+1)-bit subtract means the trial failed.
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/pipeline_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, runs a 32-iteration
// shift-add multiply or restoring divide, and stalls EX while busy.
module pipeline_muldiv_ctrl
    import pipeline_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = ITERS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mfreq,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             divzero
);

    localparam int CW = $clog2(ITERS);

    md_state_e          state;
    md_state_e          state_next;
    md_op_e             op_e;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic               accept;
    logic               signed_op;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] product_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign op_e      = md_op_e'(op);
    assign signed_op = op_is_signed(op_e);
    assign busy      = (state != S_IDLE);
    assign accept    = start & !busy;
    assign stall     = busy & (start | mfreq | mthi | mtlo);
    assign mag_a     = (signed_op && srca[WIDTH-1]) ? -srca : srca;
    assign mag_b     = (signed_op && srcb[WIDTH-1]) ? -srcb : srcb;

    // Remainder follows the dividend's sign; quotient/product flip on sign mismatch.
    assign product_fixed = (sign_a ^ sign_b) ? -acc : acc;
    assign quot_fixed    = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fixed     = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    pipeline_muldiv_ctrl_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_CALC;
            S_CALC:  if (count == CW'(ITERS - 1)) state_next = S_FIXUP;
            S_FIXUP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            divzero <= 1'b0;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (accept) begin
                        is_div  <= op_is_div(op_e);
                        sign_a  <= signed_op & srca[WIDTH-1];
                        sign_b  <= signed_op & srcb[WIDTH-1];
                        // Multiply: operand = multiplicand, acc low = multiplier.
                        // Divide:   operand = divisor,      acc low = dividend.
                        operand <= op_is_div(op_e) ? mag_b : mag_a;
                        acc     <= {{WIDTH{1'b0}}, op_is_div(op_e) ? mag_a : mag_b};
                        count   <= '0;
                        divzero <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                end
                S_FIXUP: begin
                    if (is_div) begin
                        hi      <= rem_fixed;
                        lo      <= quot_fixed;
                        divzero <= (operand == '0);
                    end else begin
                        {hi, lo} <= product_fixed;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_muldiv_ctrl.sv
// Self-checking bench for pipeline_muldiv_ctrl: a cycle-count model with
// plain-arithmetic results checked every cycle, plus literal spot checks.
module tb_pipeline_muldiv_ctrl;

    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        reset, start, mfreq, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] srca, srcb, wdata;
    logic [31:0] hi, lo;
    logic        busy, stall, done, divzero;

    int checks = 0;
    int errors = 0;

    // Model state
    int          m_cnt = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;

    pipeline_muldiv_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .mfreq(mfreq), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .stall(stall),
        .done(done), .divzero(divzero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of one operation, {divzero, hi, lo}, from plain integer arithmetic.
    function automatic logic [64:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
            2'b10: begin
                if (b == 0) begin
                    q = 32'hFFFF_FFFF;
                    r = (sa < 0) ? 32'(-sa) : a;
                    if (sa < 0) begin q = -q; r = -r; end
                end else begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end
                return {(b == 0), r, q};
            end
            default: begin
                if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
                else begin q = a / b; r = a % b; end
                return {(b == 0), r, q};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1;
                end
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
                if (start) begin
                    {p_dz, p_hi, p_lo} = model_result(op, srca, srcb);
                    m_cnt = LAT;
                    m_dz  = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("busy", 32'(busy), 32'(m_cnt > 0));
            check("done", 32'(done), 32'(m_done));
            check("divzero", 32'(divzero), 32'(m_dz));
            check("stall", 32'(stall), 32'((m_cnt > 0) && (start || mfreq || mthi || mtlo)));
        end
    end

    // Call at posedge+1; holds start until the unit accepts it.
    task automatic issue_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic idle, accepted;
        accepted = 1'b0;
        op = o; srca = a; srcb = b; start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            idle = !busy;
            @(posedge clk);
            #1;
            if (idle) begin accepted = 1'b1; break; end
        end
        start = 1'b0;
        op = 2'($urandom); srca = $urandom; srcb = $urandom;
        check("start_accepted", 32'(accepted), 32'd1);
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if (done) begin seen = 1'b1; break; end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        @(posedge clk);
        #1;
        issue_start(o, a, b);
        wait_done();
        check("lit_hi", hi, exp_hi);
        check("lit_lo", lo, exp_lo);
        check("lit_divzero", 32'(divzero), 32'(exp_dz));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mfreq = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; srca = '0; srcb = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_hi", hi, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        #1 reset = 1'b0;

        // multu max*max, then done must drop the following cycle
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        check("busy_after_done", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        check("done_once", 32'(done), 32'd0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // mf instruction parked in EX until the result lands
        @(posedge clk);
        #1;
        issue_start(2'b01, 32'h0001_0000, 32'h0001_0000);
        repeat (4) @(posedge clk);
        #1 mfreq = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if (!stall) break;
        end
        check("mf_stall_released", 32'(stall), 32'd0);
        check("mf_sees_hi", hi, 32'h1);
        check("mf_sees_lo", lo, 32'h0);
        #1 mfreq = 1'b0;

        // divide by zero, then the next start clears the flag
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        #1;
        issue_start(2'b01, 32'd2, 32'd3);
        check("dz_cleared_on_start", 32'(divzero), 32'd0);
        wait_done();
        check("lit_lo_2x3", lo, 32'd6);

        // reset during CALC iteration 10
        @(posedge clk);
        #1;
        issue_start(2'b01, 32'd123, 32'd456);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        repeat (40) @(posedge clk);

        // mthi / mtlo while idle
        #1 mthi = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk);
        #1 mthi = 1'b0;
        #1 check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo_kept", lo, 32'h0);
        #1 mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_ABCD;
        @(posedge clk);
        #1 mthi = 1'b0; mtlo = 1'b0;
        #1 check("mthilo_hi", hi, 32'h0000_ABCD);
        check("mthilo_lo", lo, 32'h0000_ABCD);

        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

        // back-to-back: second start presented during FIXUP
        @(posedge clk);
        #1;
        issue_start(2'b11, 32'd1000, 32'd33);
        repeat (31) @(posedge clk);
        #1;
        issue_start(2'b10, 32'd50, 32'hFFFF_FFF9);
        wait_done();
        check("b2b_lo", lo, 32'hFFFF_FFF9);
        check("b2b_hi", hi, 32'd1);

        repeat (3) @(posedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
